// File: rtl/burst_pkg.sv
// ============================================================================
//  Module : burst_pkg
//  Brief  : Shared state encoding and width helpers for the burst_drain block.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int sum_w(input int dw, input int depth);
        return dw + $clog2(depth);
    endfunction

    // Widths for the default DW=4, DEPTH=8 configuration
    localparam int IDX_W = idx_w(8);
    localparam int LVL_W = lvl_w(8);
    localparam int SUM_W = sum_w(4, 8);

endpackage : burst_pkg

`default_nettype wire

// File: rtl/burst_mem.sv
// ============================================================================
//  Module : burst_mem
//  Brief  : DEPTH x DW register array, one synchronous write, one async read.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module burst_mem #(
    parameter int DW    = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    // Contents are deliberately left out of reset
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : burst_mem

`default_nettype wire

// File: rtl/burst_drain.sv
// ============================================================================
//  Module : burst_drain
//  Brief  : Collects DEPTH samples, then replays them in order on valid/ready.
//           Optional burst accumulator enabled by macro BURST_DRAIN_SUM_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module burst_drain
    import burst_pkg::*;
#(
    parameter int DW    = 4,
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DW-1:0]                 in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DW-1:0]                 out_data,
    output logic                          out_last,
    output logic                          done,
    output logic [$clog2(DEPTH+1)-1:0]    fill_level,
    output logic [DW+$clog2(DEPTH)-1:0]   sum
);

    localparam int c_IDX_W = idx_w(DEPTH);
    localparam int c_LVL_W = lvl_w(DEPTH);
    localparam int c_SUM_W = sum_w(DW, DEPTH);

    localparam logic [c_IDX_W-1:0] c_LAST    = c_IDX_W'(DEPTH - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);
    localparam logic [c_LVL_W-1:0] c_LVL_ONE = c_LVL_W'(1);

    state_e               state_q, state_d;
    logic [c_IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic [c_IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic [c_LVL_W-1:0]   fill_q, fill_d;
    logic                 done_q, done_d;

    logic                 w_wr_fire;
    logic                 w_rd_fire;
    logic [DW-1:0]        w_rd_data;

    assign in_ready   = (state_q == FILL);
    assign out_valid  = (state_q == DRAIN);
    assign w_wr_fire  = in_valid && in_ready;
    assign w_rd_fire  = out_valid && out_ready;
    assign out_data   = out_valid ? w_rd_data : '0;
    assign out_last   = out_valid && (rd_idx_q == c_LAST);
    assign done       = done_q;
    assign fill_level = fill_q;

    burst_mem #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_wr_fire),
        .waddr (wr_idx_q),
        .wdata (in_data),
        .raddr (rd_idx_q),
        .rdata (w_rd_data)
    );

    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        fill_d   = fill_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                wr_idx_d = '0;
                rd_idx_d = '0;
                if (en) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (w_wr_fire) begin
                    fill_d = fill_q + c_LVL_ONE;
                    if (wr_idx_q == c_LAST) begin
                        state_d = DRAIN;
                    end else begin
                        wr_idx_d = wr_idx_q + c_IDX_ONE;
                    end
                end
            end
            DRAIN: begin
                if (w_rd_fire) begin
                    fill_d = fill_q - c_LVL_ONE;
                    if (rd_idx_q == c_LAST) begin
                        state_d  = IDLE;
                        done_d   = 1'b1;
                        wr_idx_d = '0;
                        rd_idx_d = '0;
                    end else begin
                        rd_idx_d = rd_idx_q + c_IDX_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            fill_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            fill_q   <= fill_d;
            done_q   <= done_d;
        end
    end

`ifdef BURST_DRAIN_SUM_EN
    logic [c_SUM_W-1:0] sum_q, sum_d;

    // Cleared on the arming cycle so the value survives through DRAIN and IDLE
    always_comb begin
        sum_d = sum_q;
        if ((state_q == IDLE) && en) begin
            sum_d = '0;
        end else if (w_wr_fire) begin
            sum_d = sum_q + c_SUM_W'(in_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;
`else
    assign sum = '0;
`endif

endmodule : burst_drain

`default_nettype wire

// File: tb/tb_burst_drain.sv
// ============================================================================
//  Module : tb_burst_drain
//  Brief  : Self-checking bench for burst_drain against a queue-based model.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_burst_drain;

    localparam int DW    = 4;
    localparam int DEPTH = 8;
`ifdef BURST_DRAIN_SUM_EN
    localparam bit SUM_ON = 1'b1;
`else
    localparam bit SUM_ON = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          en        = 1'b0;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          done;
    logic [3:0]    fill_level;
    logic [6:0]    sum;

    always #5 clk = ~clk;

    burst_drain #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .done       (done),
        .fill_level (fill_level),
        .sum        (sum)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: phase 0 waiting for en, 1 collecting, 2 replaying
    int m_phase = 0;
    int m_buf[$];
    int m_rd    = 0;
    int m_sum   = 0;
    bit m_done  = 1'b0;
    bit checking = 1'b0;

    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_phase = 0;
            m_buf.delete();
            m_rd    = 0;
            m_sum   = 0;
        end else if (m_phase == 0) begin
            if (en) begin
                m_phase = 1;
                m_buf.delete();
                m_sum = 0;
            end
        end else if (m_phase == 1) begin
            if (in_valid) begin
                m_buf.push_back(int'(in_data));
                m_sum += int'(in_data);
                if (m_buf.size() == DEPTH) begin
                    m_phase = 2;
                    m_rd    = 0;
                end
            end
        end else if (out_ready) begin
            if (m_rd == DEPTH - 1) begin
                m_phase = 0;
                m_rd    = 0;
                m_done  = 1'b1;
                m_buf.delete();
            end else begin
                m_rd++;
            end
        end
    end

    int          cyc         = 0;
    logic [31:0] got_word    = '0;
    int          n_got       = 0;
    int          last_pos    = 0;
    int          last_sum    = 0;
    int          last_hs_cyc = 0;
    int          fill_cyc    = 0;
    int          done_cnt    = 0;
    logic        prev_ir     = 1'b0;

    always @(negedge clk) begin
        int e_lvl;
        int e_od;
        cyc++;
        if (checking) begin
            e_lvl = (m_phase == 1) ? m_buf.size() : (m_phase == 2) ? DEPTH - m_rd : 0;
            e_od  = (m_phase == 2) ? m_buf[m_rd] : 0;
            chk("in_ready",   32'(in_ready),   32'(m_phase == 1));
            chk("out_valid",  32'(out_valid),  32'(m_phase == 2));
            chk("out_data",   32'(out_data),   32'(e_od));
            chk("out_last",   32'(out_last),   32'((m_phase == 2) && (m_rd == DEPTH - 1)));
            chk("done",       32'(done),       32'(m_done));
            chk("fill_level", 32'(fill_level), 32'(e_lvl));
            chk("sum",        32'(sum),        SUM_ON ? 32'(m_sum) : 32'd0);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            got_word = {got_word[27:0], out_data};
            n_got++;
            if (out_last === 1'b1) begin
                last_pos    = n_got;
                last_sum    = int'(sum);
                last_hs_cyc = cyc;
            end
        end
        if (done === 1'b1) done_cnt++;
        if (in_ready === 1'b1 && prev_ir !== 1'b1) fill_cyc = cyc;
        prev_ir = in_ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full burst: arm, write 8 nibbles of data (MSB first), drain to done
    task automatic burst(input string name, input logic [31:0] data, input bit gaps,
                         input bit bp, input bit hold_en, input int exp_sum);
        int  d0;
        bit  pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        got_word  = '0;
        n_got     = 0;
        last_pos  = 0;
        d0        = done_cnt;
        out_ready = !bp;
        en        = 1'b1;
        tick();
        if (!hold_en) en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = data[31 - 4*i -: 4];
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 80 && done_cnt == d0; k++) begin
            out_ready = bp ? pat[k % 4] : 1'b1;
            tick();
        end
        out_ready = 1'b1;
        chk({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({name, "_data"},        got_word,           data);
        chk({name, "_last_pos"},    32'(last_pos),      32'd8);
        chk({name, "_sum"},         32'(last_sum),      SUM_ON ? 32'(exp_sum) : 32'd0);
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        tick();
        checking = 1'b1;
        tick();
        chk("reset_fill_level", 32'(fill_level), 32'd0);
        chk("reset_in_ready",   32'(in_ready),   32'd0);
        chk("reset_out_valid",  32'(out_valid),  32'd0);
        chk("reset_sum",        32'(sum),        32'd0);
        rst = 1'b0;
        tick();

        burst("basic", 32'h12345678, 1'b0, 1'b0, 1'b0, 36);
        burst("backpressure", 32'h87654321, 1'b0, 1'b1, 1'b0, 36);
        burst("gaps", 32'h31415926, 1'b1, 1'b0, 1'b0, 31);

        // Reset after three accepted writes discards the burst
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i + 5);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_fill_before", 32'(fill_level), 32'd3);
        d0  = done_cnt;
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_in_ready",   32'(in_ready),   32'd0);
        chk("midrst_fill_level", 32'(fill_level), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);

        burst("after_rst", 32'h12345678, 1'b0, 1'b0, 1'b0, 36);

        burst("rearm", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 120);
        tick();
        tick();
        chk("rearm_latency", 32'(fill_cyc - last_hs_cyc), 32'd2);
        en  = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_burst_drain

`default_nettype wire
